keypad_scan_ctrl: RTL and testbench

- Scans a ROWS x COLS switch matrix by driving one active-low row at a time.
- Samples the column inputs and debounces every key in time-multiplexed fashion, sharing one sequencer instead of using one debouncer per key.
- Reports press/release events through a valid/ready event FIFO and exposes the debounced key bitmap.
- Sits between the board keypad pins and the command/UI logic.

---
 rtl/keypad_scan_ctrl_pkg.sv | 24 ++
 rtl/keypad_scan_ctrl_if.sv | 12 +
 rtl/cdc_sync.sv | 21 ++
 rtl/keypad_scan_ctrl_fifo.sv | 47 ++++
 rtl/keypad_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types for the keypad scanner: FSM states, event record, key-index width helper.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_COMPARE,
    ST_NEXT
  } scan_state_t;

  // Widest key index the event record can carry (8x8 matrix).
  localparam int MAX_KW = 6;

  typedef struct packed {
    logic [MAX_KW-1:0] code;
    logic              press;
  } key_ev_t;

  function automatic int kw_width(input int keys);
    return (keys < 2) ? 1 : $clog2(keys);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Press/release event stream from the keypad scanner to its consumer.
interface keypad_scan_ctrl_if #(
  parameter int KW = 4
);
  logic          ev_valid;
  logic          ev_ready;
  logic [KW-1:0] ev_code;
  logic          ev_press;

  modport master (output ev_valid, output ev_code, output ev_press, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_press, output ev_ready);
endinterface

// File: rtl/cdc_sync.sv
// Two-flop synchronizer for a single asynchronous input bit.
module CDCSync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module key_event_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-multiplexed keypad scanner with one shared debounce sequencer and a press/release event FIFO.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE         = 500,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int EV_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [ROWS-1:0]      row_n,
  input  logic [COLS-1:0]      col_n,
  keypad_scan_ctrl_if.master   ev,
  output logic [ROWS*COLS-1:0] key_state,
  output logic                 overflow,
  input  logic                 clr_overflow
);
  localparam int NK = ROWS * COLS;
  localparam int KW = kw_width(NK);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SETTLE);

  logic [COLS-1:0] col_q_n, col_closed, samp;
  scan_state_t     state;
  logic [RW-1:0]   r, r_nxt;
  logic [CW-1:0]   c;
  logic [SW-1:0]   settle;
  logic [KW-1:0]   kidx;
  logic [3:0]      deb_cnt [NK];
  logic            cur, differ, flip;
  key_ev_t         push_ev, head_ev;
  logic            full, empty, pop, drop;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_sync
    CDCSync u_sync (.clk(clk), .rst_n(rst_n), .d(col_n[gi]), .q(col_q_n[gi]));
  end
  assign col_closed = ~col_q_n;

  always_comb begin
    kidx          = KW'(int'(r) * COLS + int'(c));
    cur           = samp[c];
    differ        = (state == ST_COMPARE) && (cur != key_state[kidx]);
    flip          = differ && (deb_cnt[kidx] == 4'(DEBOUNCE_SCANS - 1));
    push_ev       = '0;
    push_ev.code  = MAX_KW'(kidx);
    push_ev.press = cur;
    r_nxt         = (r == RW'(ROWS - 1)) ? '0 : r + 1'b1;
  end

  // Dropping en leaves from any active state; the key compared in that same cycle still updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      r      <= '0;
      c      <= '0;
      settle <= '0;
      samp   <= '0;
      row_n  <= '1;
    end else if (state != ST_IDLE && !en) begin
      state <= ST_IDLE;
      row_n <= '1;
    end else begin
      case (state)
        ST_IDLE: if (en) begin
          state  <= ST_DRIVE;
          r      <= '0;
          settle <= '0;
          row_n  <= ~ROWS'(1);
        end
        ST_DRIVE:
          if (settle == SW'(SETTLE - 1)) state <= ST_SAMPLE;
          else settle <= settle + 1'b1;
        ST_SAMPLE: begin
          samp  <= col_closed;
          c     <= '0;
          row_n <= '1;
          state <= ST_COMPARE;
        end
        ST_COMPARE:
          if (c == CW'(COLS - 1)) state <= ST_NEXT;
          else c <= c + 1'b1;
        ST_NEXT: begin
          r      <= r_nxt;
          settle <= '0;
          row_n  <= ~(ROWS'(1) << r_nxt);
          state  <= ST_DRIVE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_state <= '0;
      for (int unsigned i = 0; i < NK; i++) deb_cnt[i] <= '0;
    end else if (state == ST_COMPARE) begin
      if (!differ) begin
        deb_cnt[kidx] <= '0;
      end else if (flip) begin
        key_state[kidx] <= cur;
        deb_cnt[kidx]   <= '0;
      end else begin
        deb_cnt[kidx] <= deb_cnt[kidx] + 4'd1;
      end
    end
  end

  key_event_fifo #(
    .WIDTH($bits(key_ev_t)),
    .DEPTH(EV_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (flip),
    .din   (push_ev),
    .pop   (ev.ev_ready),
    .dout  (head_ev),
    .full  (full),
    .empty (empty)
  );

  assign ev.ev_valid = ~empty;
  assign ev.ev_code  = KW'(head_ev.code);
  assign ev.ev_press = head_ev.press;
  assign pop         = ev.ev_valid & ev.ev_ready;
  assign drop        = flip & full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed and randomized scans of a 4x4 keypad checked against a per-scan debounce and FIFO model.
module tb_keypad_scan_ctrl;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int SETTLE = 8;
  localparam int DEB    = 3;
  localparam int DEPTH  = 4;
  localparam int NK     = ROWS * COLS;
  localparam int KW     = 4;
  localparam int RP     = SETTLE + COLS + 2;
  localparam int SP     = ROWS * RP;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            clr_overflow = 1'b0;
  logic [ROWS-1:0] row_n;
  logic [COLS-1:0] col_n;
  logic [NK-1:0]   key_state;
  logic            overflow;
  logic [NK-1:0]   pressed = '0;

  keypad_scan_ctrl_if #(.KW(KW)) ev_if ();

  keypad_scan_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .DEBOUNCE_SCANS(DEB), .EV_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .row_n        (row_n),
    .col_n        (col_n),
    .ev           (ev_if),
    .key_state    (key_state),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // Passive matrix: a column reads low when any driven row has a closed key on it.
  always_comb begin
    col_n = '1;
    for (int cc = 0; cc < COLS; cc++)
      for (int rr = 0; rr < ROWS; rr++)
        if (row_n[rr] === 1'b0 && pressed[rr*COLS+cc]) col_n[cc] = 1'b0;
  end

  logic [NK-1:0] ms;
  int            mc [NK];
  logic [4:0]    mfifo [$];
  bit            m_ovf;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_tick(input bit push, input logic [4:0] ev);
    bit pop, acc;
    if (!rst_n) begin
      mfifo.delete();
      m_ovf = 0;
      ms = '0;
      for (int i = 0; i < NK; i++) mc[i] = 0;
    end else begin
      pop = (ev_if.ev_ready == 1'b1) && (mfifo.size() > 0);
      acc = push && ((mfifo.size() < DEPTH) || pop);
      if (pop) void'(mfifo.pop_front());
      if (acc) mfifo.push_back(ev);
      if (push && !acc) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
    end
    @(posedge clk);
    #1;
    chk("ev_valid", ev_if.ev_valid, mfifo.size() > 0);
    if (mfifo.size() > 0) chk("ev_head", {ev_if.ev_code, ev_if.ev_press}, mfifo[0]);
    chk("overflow", overflow, m_ovf);
    chk("key_state", key_state, ms);
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin
      m_tick(1'b0, '0);
      chk("row_n_idle", row_n, 4'hF);
    end
  endtask

  // One full scan period from a scan boundary (or from IDLE); stop_i ends it early by en=0 or reset.
  task automatic run_scan(input logic [NK-1:0] pat, input int stop_i, input bit stop_rst,
                          input int pulse_i, input bit rnd);
    pressed = pat;
    en = 1'b1;
    for (int i = 0; i < SP; i++) begin
      bit         push;
      logic [4:0] ev;
      logic [3:0] exp_row;
      int         j, r, c, k;
      push = 0;
      ev = '0;
      if (i == stop_i) begin
        if (stop_rst) rst_n = 1'b0;
        else en = 1'b0;
      end
      if (rnd) begin
        ev_if.ev_ready = ($urandom_range(0, 3) != 0);
        clr_overflow = ($urandom_range(0, 15) == 0);
      end
      if (i == pulse_i) ev_if.ev_ready = 1'b1;
      if ((i < stop_i || (i == stop_i && !stop_rst)) && i >= SETTLE + 2) begin
        j = i - (SETTLE + 2);
        r = j / RP;
        c = j % RP;
        if (c < COLS) begin
          k = r * COLS + c;
          if (pat[k] == ms[k]) mc[k] = 0;
          else if (mc[k] == DEB - 1) begin
            ms[k] = pat[k];
            mc[k] = 0;
            push = 1;
            ev = {4'(k), pat[k]};
          end else mc[k]++;
        end
      end
      m_tick(push, ev);
      if (i == pulse_i) ev_if.ev_ready = 1'b0;
      exp_row = (i < stop_i && (i % RP) < SETTLE + 1) ? ~(4'b0001 << (i / RP)) : 4'hF;
      chk("row_n", row_n, exp_row);
    end
    clr_overflow = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NK-1:0] pat;
    ev_if.ev_ready = 1'b0;
    ms = '0;
    m_ovf = 0;
    for (int i = 0; i < NK; i++) mc[i] = 0;

    rst_n = 1'b0;
    repeat (3) begin
      m_tick(1'b0, '0);
      chk("row_n_reset", row_n, 4'hF);
    end
    rst_n = 1'b1;
    idle(2);

    ev_if.ev_ready = 1'b1;
    run_scan('0, SP, 0, -1, 0);

    repeat (3) run_scan(16'h0040, SP, 0, -1, 0);
    repeat (3) run_scan(16'h0000, SP, 0, -1, 0);

    repeat (2) run_scan(16'h0040, SP, 0, -1, 0);
    run_scan(16'h0000, SP, 0, -1, 0);
    run_scan(16'h0040, SP, 0, -1, 0);
    run_scan(16'h0000, SP, 0, -1, 0);
    repeat (3) run_scan(16'h0040, SP, 0, -1, 0);
    repeat (3) run_scan(16'h0000, SP, 0, -1, 0);

    ev_if.ev_ready = 1'b0;
    repeat (3) run_scan(16'h001F, SP, 0, -1, 0);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;

    repeat (2) run_scan(16'h003F, SP, 0, -1, 0);
    run_scan(16'h003F, SP, 0, RP + SETTLE + 3, 0);
    ev_if.ev_ready = 1'b1;
    idle(8);
    repeat (3) run_scan(16'h0000, SP, 0, -1, 0);

    repeat (2) run_scan(16'h0E00, SP, 0, -1, 0);
    run_scan(16'h0E00, 2 * RP + SETTLE + 3, 0, -1, 0);
    run_scan(16'h0E00, SP, 0, -1, 0);
    repeat (3) run_scan(16'h0000, SP, 0, -1, 0);

    pat = '0;
    repeat (24) begin
      if ($urandom_range(0, 2) == 0) pat = NK'($urandom & $urandom & $urandom);
      run_scan(pat, SP, 0, -1, 1);
    end

    ev_if.ev_ready = 1'b1;
    pat = {ms[NK-1:4], ~ms[3:0]};
    repeat (2) run_scan(pat, SP, 0, -1, 0);
    ev_if.ev_ready = 1'b0;
    run_scan(pat, 30, 1, -1, 0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
